// File: rtl/axi_xbar.sv
// AXI4-Lite 1-to-2 address-decoding crossbar: routes one master port to S0, S1 or an
// internal error responder; independent read and write paths, one outstanding each.
module axi_xbar #(
    parameter logic [31:0] S0_BASE = 32'h8000_0000,
    parameter logic [31:0] S0_MASK = 32'hF800_0000,
    parameter logic [31:0] S1_BASE = 32'hA000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_arvalid,
    output logic        m_arready,
    input  logic [31:0] m_araddr,
    output logic        m_rvalid,
    input  logic        m_rready,
    output logic [31:0] m_rdata,
    output logic        m_rresp,
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_awaddr,
    input  logic        m_wvalid,
    output logic        m_wready,
    input  logic [31:0] m_wdata,
    input  logic [7:0]  m_wmask,
    output logic        m_bvalid,
    input  logic        m_bready,
    output logic        m_bresp,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    output logic [31:0] s0_araddr,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    input  logic [31:0] s0_rdata,
    input  logic        s0_rresp,
    output logic        s0_awvalid,
    input  logic        s0_awready,
    output logic [31:0] s0_awaddr,
    output logic        s0_wvalid,
    input  logic        s0_wready,
    output logic [31:0] s0_wdata,
    output logic [7:0]  s0_wmask,
    input  logic        s0_bvalid,
    output logic        s0_bready,
    input  logic        s0_bresp,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    output logic [31:0] s1_araddr,
    input  logic        s1_rvalid,
    output logic        s1_rready,
    input  logic [31:0] s1_rdata,
    input  logic        s1_rresp,
    output logic        s1_awvalid,
    input  logic        s1_awready,
    output logic [31:0] s1_awaddr,
    output logic        s1_wvalid,
    input  logic        s1_wready,
    output logic [31:0] s1_wdata,
    output logic [7:0]  s1_wmask,
    input  logic        s1_bvalid,
    output logic        s1_bready,
    input  logic        s1_bresp
);
    typedef enum logic [1:0] {SEL_NONE, SEL_0, SEL_1, SEL_ERR} sel_e;
    typedef enum logic {R_IDLE, R_BUSY} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    function automatic sel_e decode(input logic [31:0] addr);
        if ((addr & S0_MASK) == S0_BASE)      return SEL_0;
        else if ((addr & S1_MASK) == S1_BASE) return SEL_1;
        else                                  return SEL_ERR;
    endfunction

    r_state_e r_state, r_state_nx;
    w_state_e w_state, w_state_nx;
    sel_e     rsel, rsel_nx, wsel, wsel_nx;
    sel_e     ar_dec, aw_dec;
    logic     w_early, w_early_nx;

    assign ar_dec    = decode(m_araddr);
    assign aw_dec    = decode(m_awaddr);
    assign s0_araddr = m_araddr;
    assign s1_araddr = m_araddr;
    assign s0_awaddr = m_awaddr;
    assign s1_awaddr = m_awaddr;
    assign s0_wdata  = m_wdata;
    assign s1_wdata  = m_wdata;
    assign s0_wmask  = m_wmask;
    assign s1_wmask  = m_wmask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            rsel    <= SEL_NONE;
            w_state <= W_IDLE;
            wsel    <= SEL_NONE;
            w_early <= 1'b0;
        end else begin
            r_state <= r_state_nx;
            rsel    <= rsel_nx;
            w_state <= w_state_nx;
            wsel    <= wsel_nx;
            w_early <= w_early_nx;
        end
    end

    // Read path: zero-latency AR routing, then R steered from the latched target.
    always_comb begin
        r_state_nx = r_state;
        rsel_nx    = rsel;
        m_arready  = 1'b0;
        m_rvalid   = 1'b0;
        m_rdata    = 32'h0;
        m_rresp    = 1'b0;
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        s0_rready  = 1'b0;
        s1_rready  = 1'b0;
        if (!reset) begin
            case (r_state)
                R_IDLE: begin
                    s0_arvalid = m_arvalid && (ar_dec == SEL_0);
                    s1_arvalid = m_arvalid && (ar_dec == SEL_1);
                    case (ar_dec)
                        SEL_0:   m_arready = m_arvalid && s0_arready;
                        SEL_1:   m_arready = m_arvalid && s1_arready;
                        default: m_arready = m_arvalid;
                    endcase
                    if (m_arvalid && m_arready) begin
                        r_state_nx = R_BUSY;
                        rsel_nx    = ar_dec;
                    end
                end
                R_BUSY: begin
                    case (rsel)
                        SEL_0: begin
                            m_rvalid  = s0_rvalid;
                            m_rdata   = s0_rdata;
                            m_rresp   = s0_rresp;
                            s0_rready = m_rready;
                        end
                        SEL_1: begin
                            m_rvalid  = s1_rvalid;
                            m_rdata   = s1_rdata;
                            m_rresp   = s1_rresp;
                            s1_rready = m_rready;
                        end
                        default: begin
                            m_rvalid = 1'b1;
                            m_rresp  = 1'b1;
                        end
                    endcase
                    if (m_rvalid && m_rready) begin
                        r_state_nx = R_IDLE;
                        rsel_nx    = SEL_NONE;
                    end
                end
                default: r_state_nx = R_IDLE;
            endcase
        end
    end

    // Write path; w_early remembers a W that a device took before its AW so it is not resent.
    always_comb begin
        w_state_nx = w_state;
        wsel_nx    = wsel;
        w_early_nx = w_early;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        m_bvalid   = 1'b0;
        m_bresp    = 1'b0;
        s0_awvalid = 1'b0;
        s1_awvalid = 1'b0;
        s0_wvalid  = 1'b0;
        s1_wvalid  = 1'b0;
        s0_bready  = 1'b0;
        s1_bready  = 1'b0;
        if (!reset) begin
            case (w_state)
                W_IDLE: begin
                    s0_awvalid = m_awvalid && (aw_dec == SEL_0);
                    s1_awvalid = m_awvalid && (aw_dec == SEL_1);
                    case (aw_dec)
                        SEL_0:   m_awready = m_awvalid && s0_awready;
                        SEL_1:   m_awready = m_awvalid && s1_awready;
                        default: m_awready = m_awvalid;
                    endcase
                    if (!w_early) begin
                        s0_wvalid = m_wvalid && s0_awvalid;
                        s1_wvalid = m_wvalid && s1_awvalid;
                        case (aw_dec)
                            SEL_0:   m_wready = m_awvalid && s0_wready;
                            SEL_1:   m_wready = m_awvalid && s1_wready;
                            default: m_wready = m_awvalid;
                        endcase
                    end
                    if (m_awvalid && m_awready) begin
                        wsel_nx    = aw_dec;
                        w_early_nx = 1'b0;
                        w_state_nx = (w_early || (m_wvalid && m_wready)) ? W_RESP : W_DATA;
                    end else if (m_wvalid && m_wready) begin
                        w_early_nx = 1'b1;
                    end
                end
                W_DATA: begin
                    case (wsel)
                        SEL_0: begin
                            s0_wvalid = m_wvalid;
                            m_wready  = s0_wready;
                        end
                        SEL_1: begin
                            s1_wvalid = m_wvalid;
                            m_wready  = s1_wready;
                        end
                        default: m_wready = 1'b1;
                    endcase
                    if (m_wvalid && m_wready) w_state_nx = W_RESP;
                end
                W_RESP: begin
                    case (wsel)
                        SEL_0: begin
                            m_bvalid  = s0_bvalid;
                            m_bresp   = s0_bresp;
                            s0_bready = m_bready;
                        end
                        SEL_1: begin
                            m_bvalid  = s1_bvalid;
                            m_bresp   = s1_bresp;
                            s1_bready = m_bready;
                        end
                        default: begin
                            m_bvalid = 1'b1;
                            m_bresp  = 1'b1;
                        end
                    endcase
                    if (m_bvalid && m_bready) begin
                        w_state_nx = W_IDLE;
                        wsel_nx    = SEL_NONE;
                    end
                end
                default: w_state_nx = W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_xbar.sv
// Directed bench for axi_xbar with a response scoreboard for R and B channels.
module tb_axi_xbar;
    logic        clk, reset;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rresp;
    logic [31:0] m_araddr, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready, m_bresp;
    logic [31:0] m_awaddr, m_wdata;
    logic [7:0]  m_wmask;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rresp;
    logic [31:0] s0_araddr, s0_rdata;
    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready, s0_bresp;
    logic [31:0] s0_awaddr, s0_wdata;
    logic [7:0]  s0_wmask;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rresp;
    logic [31:0] s1_araddr, s1_rdata;
    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready, s1_bresp;
    logic [31:0] s1_awaddr, s1_wdata;
    logic [7:0]  s1_wmask;

    typedef struct packed {
        logic [31:0] data;
        logic        resp;
    } rexp_t;

    rexp_t rq[$];
    logic  bq[$];
    int    checks = 0;
    int    failures = 0;

    axi_xbar dut (
        .clk(clk), .reset(reset),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
        .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr),
        .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wmask(s0_wmask),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp),
        .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr),
        .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wmask(s1_wmask),
        .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bresp(s1_bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected read response and compare it to the R channel now.
    task automatic rd_pop(input string tag);
        rexp_t e;
        chk({tag, "_rq_nonempty"}, 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
            e = rq.pop_front();
            chk({tag, "_rvalid"}, 32'(m_rvalid), 32'd1);
            chk({tag, "_rdata"}, m_rdata, e.data);
            chk({tag, "_rresp"}, 32'(m_rresp), 32'(e.resp));
        end
    endtask

    task automatic b_pop(input string tag);
        logic e;
        chk({tag, "_bq_nonempty"}, 32'(bq.size() != 0), 32'd1);
        if (bq.size() != 0) begin
            e = bq.pop_front();
            chk({tag, "_bvalid"}, 32'(m_bvalid), 32'd1);
            chk({tag, "_bresp"}, 32'(m_bresp), 32'(e));
        end
    endtask

    initial begin
        reset = 1'b1;
        m_arvalid = 0; m_araddr = 32'h0; m_rready = 0;
        m_awvalid = 0; m_awaddr = 32'h0; m_wvalid = 0; m_wdata = 32'h0; m_wmask = 8'h0; m_bready = 0;
        s0_arready = 0; s0_rvalid = 0; s0_rdata = 32'h0; s0_rresp = 0;
        s0_awready = 0; s0_wready = 0; s0_bvalid = 0; s0_bresp = 0;
        s1_arready = 0; s1_rvalid = 0; s1_rdata = 32'h0; s1_rresp = 0;
        s1_awready = 0; s1_wready = 0; s1_bvalid = 0; s1_bresp = 0;

        // Reset state, with an unmapped AR and AW offered to show reset holds readies low.
        m_arvalid = 1; m_araddr = 32'h0000_1000; m_awvalid = 1; m_awaddr = 32'h0000_2000;
        #2;
        chk("rst_arready", 32'(m_arready), 0);
        chk("rst_awready", 32'(m_awready), 0);
        chk("rst_wready", 32'(m_wready), 0);
        chk("rst_rvalid", 32'(m_rvalid), 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_rresp", 32'(m_rresp), 0);
        chk("rst_bvalid", 32'(m_bvalid), 0);
        chk("rst_bresp", 32'(m_bresp), 0);
        m_arvalid = 0; m_awvalid = 0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Read S0 with a 2-cycle device latency.
        m_arvalid = 1; m_araddr = 32'h8000_0010; s0_arready = 1;
        #1;
        chk("r0_s0_arvalid", 32'(s0_arvalid), 1);
        chk("r0_s1_arvalid", 32'(s1_arvalid), 0);
        chk("r0_arready", 32'(m_arready), 1);
        chk("r0_araddr", s0_araddr, 32'h8000_0010);
        rq.push_back('{data: 32'h1234_5678, resp: 1'b0});
        tick();
        m_arvalid = 0; s0_arready = 0;
        #1;
        chk("r0_busy_rvalid", 32'(m_rvalid), 0);
        tick();
        s0_rvalid = 1; s0_rdata = 32'h1234_5678; s0_rresp = 0; m_rready = 1;
        #1;
        chk("r0_s0_rready", 32'(s0_rready), 1);
        chk("r0_s1_rready", 32'(s1_rready), 0);
        rd_pop("r0");
        tick();
        s0_rvalid = 0; m_rready = 0;
        #1;
        chk("r0_done_rvalid", 32'(m_rvalid), 0);

        // Write S1 with AW and W together.
        m_awvalid = 1; m_awaddr = 32'hA000_03F8; m_wvalid = 1; m_wdata = 32'h41; m_wmask = 8'h01;
        s1_awready = 1; s1_wready = 1;
        #1;
        chk("w1_s1_awvalid", 32'(s1_awvalid), 1);
        chk("w1_s1_wvalid", 32'(s1_wvalid), 1);
        chk("w1_s0_awvalid", 32'(s0_awvalid), 0);
        chk("w1_s0_wvalid", 32'(s0_wvalid), 0);
        chk("w1_awready", 32'(m_awready), 1);
        chk("w1_wready", 32'(m_wready), 1);
        chk("w1_wdata", s1_wdata, 32'h41);
        chk("w1_wmask", 32'(s1_wmask), 32'h01);
        bq.push_back(1'b0);
        tick();
        m_awvalid = 0; m_wvalid = 0; s1_awready = 0; s1_wready = 0;
        #1;
        chk("w1_resp_awready", 32'(m_awready), 0);
        s1_bvalid = 1; s1_bresp = 0; m_bready = 1;
        #1;
        chk("w1_s1_bready", 32'(s1_bready), 1);
        chk("w1_s0_bready", 32'(s0_bready), 0);
        b_pop("w1");
        tick();
        s1_bvalid = 0; m_bready = 0;
        // Back in IDLE one cycle after B: an unmapped write is taken by the error responder.
        m_awvalid = 1; m_awaddr = 32'h0000_2000; m_wvalid = 1; m_wdata = 32'h55;
        #1;
        chk("werr_awready", 32'(m_awready), 1);
        chk("werr_wready", 32'(m_wready), 1);
        chk("werr_devvalid", 32'({s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid}), 0);
        bq.push_back(1'b1);
        tick();
        m_awvalid = 0; m_wvalid = 0; m_bready = 1;
        #1;
        b_pop("werr");
        tick();
        m_bready = 0;
        #1;
        chk("werr_done_bvalid", 32'(m_bvalid), 0);

        // Unmapped read answered internally.
        m_arvalid = 1; m_araddr = 32'h0000_1000;
        #1;
        chk("rerr_arready", 32'(m_arready), 1);
        chk("rerr_devvalid", 32'({s0_arvalid, s1_arvalid}), 0);
        rq.push_back('{data: 32'h0, resp: 1'b1});
        tick();
        m_arvalid = 0; m_rready = 1;
        #1;
        chk("rerr_rready_dev", 32'({s0_rready, s1_rready}), 0);
        rd_pop("rerr");
        tick();
        m_rready = 0;

        // AW to S0 with W three cycles later; a second AW must wait for B.
        m_awvalid = 1; m_awaddr = 32'h8000_0000; s0_awready = 1; s0_wready = 1;
        #1;
        chk("wd_s0_awvalid", 32'(s0_awvalid), 1);
        chk("wd_s0_wvalid_idle", 32'(s0_wvalid), 0);
        tick();
        m_awaddr = 32'h8000_0100;
        #1;
        chk("wd_awready_blocked", 32'(m_awready), 0);
        chk("wd_s0_awvalid_blocked", 32'(s0_awvalid), 0);
        chk("wd_s0_wvalid_wait1", 32'(s0_wvalid), 0);
        tick();
        #1;
        chk("wd_s0_wvalid_wait2", 32'(s0_wvalid), 0);
        tick();
        m_wvalid = 1; m_wdata = 32'hAABB_CCDD; m_wmask = 8'hFF;
        #1;
        chk("wd_s0_wvalid", 32'(s0_wvalid), 1);
        chk("wd_s1_wvalid", 32'(s1_wvalid), 0);
        chk("wd_wready", 32'(m_wready), 1);
        chk("wd_awready_data", 32'(m_awready), 0);
        bq.push_back(1'b0);
        tick();
        m_wvalid = 0;
        #1;
        chk("wd_awready_resp", 32'(m_awready), 0);
        s0_bvalid = 1; s0_bresp = 0; m_bready = 1;
        #1;
        b_pop("wd");
        tick();
        s0_bvalid = 0; m_bready = 0;
        #1;
        chk("wd2_awready", 32'(m_awready), 1);
        chk("wd2_s0_awvalid", 32'(s0_awvalid), 1);
        m_wvalid = 1;
        bq.push_back(1'b0);
        tick();
        m_awvalid = 0; m_wvalid = 0; s0_awready = 0; s0_wready = 0;
        s0_bvalid = 1; m_bready = 1;
        #1;
        b_pop("wd2");
        tick();
        s0_bvalid = 0; m_bready = 0;

        // Concurrent read S1 and write S0; master holds rready low 5 cycles.
        m_arvalid = 1; m_araddr = 32'hA000_0004; s1_arready = 1;
        m_awvalid = 1; m_awaddr = 32'h8000_0040; m_wvalid = 1; m_wdata = 32'h7;
        s0_awready = 1; s0_wready = 1;
        #1;
        chk("cc_arready", 32'(m_arready), 1);
        chk("cc_awready", 32'(m_awready), 1);
        chk("cc_s1_arvalid", 32'(s1_arvalid), 1);
        chk("cc_s0_awvalid", 32'(s0_awvalid), 1);
        rq.push_back('{data: 32'hCAFE_F00D, resp: 1'b0});
        bq.push_back(1'b0);
        tick();
        m_arvalid = 0; m_awvalid = 0; m_wvalid = 0;
        s1_arready = 0; s0_awready = 0; s0_wready = 0;
        s1_rvalid = 1; s1_rdata = 32'hCAFE_F00D; s1_rresp = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                s0_bvalid = 1; m_bready = 1;
            end
            #1;
            chk($sformatf("cc_rvalid_hold%0d", i), 32'(m_rvalid), 1);
            chk($sformatf("cc_s1_rready_hold%0d", i), 32'(s1_rready), 0);
            if (i == 1) b_pop("cc");
            tick();
            s0_bvalid = 0; m_bready = 0;
        end
        m_rready = 1;
        #1;
        chk("cc_s1_rready", 32'(s1_rready), 1);
        rd_pop("cc");
        tick();
        s1_rvalid = 0; m_rready = 0;

        // Reset while a read to S0 is in flight.
        m_arvalid = 1; m_araddr = 32'h8000_0000; s0_arready = 1;
        tick();
        m_arvalid = 0; s0_arready = 0;
        s0_rvalid = 1; s0_rdata = 32'hDEAD_0000; m_rready = 1;
        #1;
        chk("rb_rvalid_pre", 32'(m_rvalid), 1);
        chk("rb_s0_rready_pre", 32'(s0_rready), 1);
        reset = 1'b1;
        #1;
        chk("rb_rvalid_rst", 32'(m_rvalid), 0);
        chk("rb_rdata_rst", m_rdata, 0);
        chk("rb_s0_rready_rst", 32'(s0_rready), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("stale_rvalid", 32'(m_rvalid), 0);
        chk("stale_s0_rready", 32'(s0_rready), 0);
        tick();
        s0_rvalid = 0; m_rready = 0;
        m_arvalid = 1; m_araddr = 32'h8000_0000; s0_arready = 1;
        #1;
        chk("pr_arready", 32'(m_arready), 1);
        rq.push_back('{data: 32'h0BAD_BEEF, resp: 1'b0});
        tick();
        m_arvalid = 0; s0_arready = 0;
        tick();
        s0_rvalid = 1; s0_rdata = 32'h0BAD_BEEF; m_rready = 1;
        #1;
        rd_pop("pr");
        tick();
        s0_rvalid = 0; m_rready = 0;
        #1;
        chk("pr_done_rvalid", 32'(m_rvalid), 0);
        chk("sb_rq_drained", 32'(rq.size()), 0);
        chk("sb_bq_drained", 32'(bq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
